// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill engine: line geometry
// (shared with the instruction cache) and the refill state encoding.
package icache_refill_pkg;

  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned BLOCK_WIDTH     = 4;
  localparam int unsigned BLOCK_SIZE      = 1 << BLOCK_WIDTH;
  localparam int unsigned LINE_ADDR_WIDTH = ADDR_WIDTH - BLOCK_WIDTH;
  localparam int unsigned LINE_BITS       = BLOCK_SIZE * 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    READ,
    DONE
  } refillState_t;

endpackage

// File: rtl/icache_refill_if.sv
// Bundle of the refill engine's cache-side and RAM-side signals.
//   master : the refill engine (drives RAM request/address and the fill)
//   slave  : the cache + RAM/arbiter environment
//   cache side : missValid, missAddr, flushIn -> ; fillValid, fillAddr, fillData, busy <-
//   RAM side   : ramReqOut, ramAddrOut -> ; ramGrantIn, ramDataIn <-
interface icache_refill_if;
  import icache_refill_pkg::*;

  logic                       missValid;
  logic [ADDR_WIDTH-1:0]      missAddr;
  logic                       flushIn;
  logic                       ramReqOut;
  logic                       ramGrantIn;
  logic [ADDR_WIDTH-1:0]      ramAddrOut;
  logic [7:0]                 ramDataIn;
  logic                       fillValid;
  logic [LINE_ADDR_WIDTH-1:0] fillAddr;
  logic [LINE_BITS-1:0]       fillData;
  logic                       busy;

  modport master (
    input  missValid, missAddr, flushIn, ramGrantIn, ramDataIn,
    output ramReqOut, ramAddrOut, fillValid, fillAddr, fillData, busy
  );

  modport slave (
    output missValid, missAddr, flushIn, ramGrantIn, ramDataIn,
    input  ramReqOut, ramAddrOut, fillValid, fillAddr, fillData, busy
  );

endinterface

// File: rtl/icache_refill.sv
// Instruction-cache refill engine: on a miss, acquires the byte-wide RAM bus,
// reads the aligned line one byte per cycle and delivers it as a one-cycle
// fill pulse.
//   clkIn   : system clock
//   resetIn : asynchronous active-low reset
//   bus     : icache_refill_if.master (miss/flush in, RAM bus, fill out, busy)
module icache_refill
  import icache_refill_pkg::*;
(
  input  logic            clkIn,
  input  logic            resetIn,
  icache_refill_if.master bus
);

  localparam int unsigned CNT_W = BLOCK_WIDTH + 1;

  refillState_t     state;
  logic [CNT_W-1:0] issueCnt;
  logic [CNT_W-1:0] rcvCnt;

  // Offset bits of the miss address carry no information for a line fill.
  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.missAddr[BLOCK_WIDTH-1:0];

  assign bus.busy = (state != IDLE);

  // Refill FSM with registered bus and fill outputs.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state          <= IDLE;
      issueCnt       <= '0;
      rcvCnt         <= '0;
      bus.ramReqOut  <= 1'b0;
      bus.ramAddrOut <= '0;
      bus.fillValid  <= 1'b0;
      bus.fillAddr   <= '0;
      bus.fillData   <= '0;
    end else begin
      bus.fillValid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.missValid && !bus.flushIn) begin
            bus.fillAddr  <= bus.missAddr[ADDR_WIDTH-1:BLOCK_WIDTH];
            bus.ramReqOut <= 1'b1;
            state         <= REQ;
          end
        end

        REQ: begin
          if (bus.flushIn) begin
            bus.ramReqOut <= 1'b0;
            state         <= IDLE;
          end else if (bus.ramGrantIn) begin
            // Byte 0's address is registered on the grant edge so it is on
            // the bus in the first READ cycle; the count starts past it.
            bus.ramAddrOut <= {bus.fillAddr, {BLOCK_WIDTH{1'b0}}};
            issueCnt       <= CNT_W'(1);
            rcvCnt         <= '0;
            state          <= READ;
          end
        end

        READ: begin
          if (bus.flushIn) begin
            bus.ramReqOut <= 1'b0;
            state         <= IDLE;
          end else begin
            if (issueCnt < CNT_W'(BLOCK_SIZE)) begin
              bus.ramAddrOut <= {bus.fillAddr, issueCnt[BLOCK_WIDTH-1:0]};
              issueCnt       <= issueCnt + CNT_W'(1);
            end
            // No byte is in flight during the first READ cycle.
            if (issueCnt > CNT_W'(1)) begin
              bus.fillData[{rcvCnt[BLOCK_WIDTH-1:0], 3'b000} +: 8] <= bus.ramDataIn;
              rcvCnt <= rcvCnt + CNT_W'(1);
              if (rcvCnt == CNT_W'(BLOCK_SIZE - 1)) begin
                bus.ramReqOut <= 1'b0;
                bus.fillValid <= 1'b1;
                state         <= DONE;
              end
            end
          end
        end

        // The line is already complete, so a flush here is ignored.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
